// File: rtl/palette_load_ctrl.sv
// Loads the custom palette RAM from an R,G,B byte stream, one 24-bit entry at a time.
// Writes are held off until the palette is not on screen or video is blanking.
module palette_load_ctrl #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             blank,
    input  logic             custom_active,
    output logic             load_color,
    output logic [23:0]      load_color_data,
    output logic [IDX_W-1:0] load_color_index,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StWaitSlot, StWrite} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       phase_q, phase_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic             slot_ok, slot_ok_q;
    logic             xfer, abort;

    logic             in_ready_d, busy_d, load_color_d, done_d, error_d;
    logic [23:0]      data_d;
    logic [IDX_W-1:0] index_d;

    assign slot_ok = blank || !custom_active;
    assign xfer    = in_valid && in_ready;
    assign abort   = start && (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= StIdle;
            idx_q            <= '0;
            phase_q          <= '0;
            r_q              <= '0;
            g_q              <= '0;
            b_q              <= '0;
            slot_ok_q        <= 1'b0;
            in_ready         <= 1'b0;
            busy             <= 1'b0;
            load_color       <= 1'b0;
            load_color_data  <= '0;
            load_color_index <= '0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            phase_q          <= phase_d;
            r_q              <= r_d;
            g_q              <= g_d;
            b_q              <= b_d;
            slot_ok_q        <= slot_ok;
            in_ready         <= in_ready_d;
            busy             <= busy_d;
            load_color       <= load_color_d;
            load_color_data  <= data_d;
            load_color_index <= index_d;
            done             <= done_d;
            error            <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        unique case (state_q)
            StIdle: ;
            StCollect: begin
                if (xfer) begin
                    case (phase_q)
                        2'd0:    r_d = in_data;
                        2'd1:    g_d = in_data;
                        default: b_d = in_data;
                    endcase
                    if (phase_q == 2'd2) begin
                        state_d = StWaitSlot;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            // Two consecutive good samples: a drop in slot_ok always blocks the next cycle.
            StWaitSlot: if (slot_ok && slot_ok_q) state_d = StWrite;
            StWrite: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    state_d = StCollect;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // A start from any state (re)begins at entry 0 and overrides the normal transition.
        if (start) begin
            state_d = StCollect;
            idx_d   = '0;
            phase_d = '0;
        end
    end

    always_comb begin
        in_ready_d   = (state_d == StCollect);
        busy_d       = (state_d != StIdle);
        load_color_d = (state_d == StWrite);
        data_d       = load_color_d ? {r_q, g_q, b_q} : load_color_data;
        index_d      = load_color_d ? idx_q : load_color_index;
        done_d       = (state_q == StWrite) && (idx_q == LastIdx) && !start;
        error_d      = abort;
    end

endmodule
